// File: rtl/ds_rx_decoder.sv
// IEEE 1355 data/strobe receiver: bit recovery, NULL sync, parity/escape checking, single-entry output hold.
// Optional idle-disconnect detection is built when DS_RX_DISCONNECT_EN is defined.
module ds_rx_decoder #(
  parameter int DISC_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_in,
  input  logic       s_in,
  input  logic       rx_ready,
  input  logic       err_clr,
  output logic       rx_valid,
  output logic       rx_ctrl,
  output logic [7:0] rx_data,
  output logic       link_up,
  output logic       err_par,
  output logic       err_esc,
  output logic       err_ovr,
  output logic       err_disc
);

  typedef enum logic [1:0] {HUNT, PARITY, FLAG, BODY} state_t;

  localparam logic [1:0] CODE_FCC = 2'b00;
  localparam logic [1:0] CODE_ESC = 2'b11;
  // Last seven bits of a NULL (ESC + FCC) in arrival order, oldest in the MSB.
  localparam logic [6:0] NULL_TAIL = 7'b1110100;

  if (DISC_CYCLES < 2) begin : g_bad_disc
    $error("DISC_CYCLES must be at least 2");
  end

  state_t     state_q, state_d;
  logic       d_s1_q, d_s1_d, d_s2_q, d_s2_d;
  logic       s_s1_q, s_s1_d, s_s2_q, s_s2_d;
  logic       tok_q, tok_d;
  logic [6:0] hist_q, hist_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] body_q, body_d;
  logic       flag_q, flag_d;
  logic       par_acc_q, par_acc_d;
  logic       par_chk_q, par_chk_d;
  logic       esc_pend_q, esc_pend_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_ctrl_q, rx_ctrl_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       link_up_q, link_up_d;
  logic       err_par_q, err_par_d;
  logic       err_esc_q, err_esc_d;
  logic       err_ovr_q, err_ovr_d;

  logic       tok, bit_vld, bit_val;
  logic [7:0] body_nx;
  logic       last_bit, deliver;
  logic       ev_par, ev_esc, ev_ovr, ev_disc;

`ifdef DS_RX_DISCONNECT_EN
  localparam int DW = $clog2(DISC_CYCLES + 1);
  logic [DW-1:0] disc_cnt_q, disc_cnt_d;
  logic          err_disc_q, err_disc_d;
`endif

  always_comb begin
    state_d    = state_q;
    d_s1_d     = d_in;
    d_s2_d     = d_s1_q;
    s_s1_d     = s_in;
    s_s2_d     = s_s1_q;
    hist_d     = hist_q;
    cnt_d      = cnt_q;
    body_d     = body_q;
    flag_d     = flag_q;
    par_acc_d  = par_acc_q;
    par_chk_d  = par_chk_q;
    esc_pend_d = esc_pend_q;
    rx_ctrl_d  = rx_ctrl_q;
    rx_data_d  = rx_data_q;
    link_up_d  = link_up_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    body_nx    = body_q;
    last_bit   = 1'b0;
    deliver    = 1'b0;
    ev_par     = 1'b0;
    ev_esc     = 1'b0;
    ev_ovr     = 1'b0;
    ev_disc    = 1'b0;

    tok     = d_s2_q ^ s_s2_q;
    tok_d   = tok;
    bit_vld = tok ^ tok_q;
    bit_val = d_s2_q;

    if (bit_vld) begin
      unique case (state_q)
        HUNT: begin
          hist_d = {hist_q[5:0], bit_val};
          if ({hist_q[5:0], bit_val} == NULL_TAIL) begin
            // The matched FCC carried body 00, so the running body parity restarts at 0.
            state_d    = PARITY;
            link_up_d  = 1'b1;
            par_acc_d  = 1'b0;
            esc_pend_d = 1'b0;
          end
        end
        PARITY: begin
          par_chk_d = bit_val ^ par_acc_q;
          state_d   = FLAG;
        end
        FLAG: begin
          if (!(par_chk_q ^ bit_val)) begin
            ev_par = 1'b1;
          end else begin
            flag_d    = bit_val;
            par_acc_d = 1'b0;
            cnt_d     = 3'd0;
            body_d    = 8'h00;
            state_d   = BODY;
          end
        end
        BODY: begin
          body_nx[cnt_q] = bit_val;
          body_d         = body_nx;
          par_acc_d      = par_acc_q ^ bit_val;
          cnt_d          = cnt_q + 3'd1;
          last_bit       = flag_q ? (cnt_q == 3'd1) : (cnt_q == 3'd7);
          if (last_bit) begin
            state_d = PARITY;
            if (esc_pend_q) begin
              esc_pend_d = 1'b0;
              if (flag_q && body_nx[1:0] == CODE_FCC) link_up_d = 1'b1;
              else                                    ev_esc    = 1'b1;
            end else if (flag_q && body_nx[1:0] == CODE_ESC) begin
              esc_pend_d = 1'b1;
            end else begin
              deliver = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (deliver) begin
      if (rx_valid_q && !rx_ready) begin
        ev_ovr = 1'b1;
      end else begin
        rx_valid_d = 1'b1;
        rx_ctrl_d  = flag_q;
        rx_data_d  = flag_q ? {6'b0, body_nx[1:0]} : body_nx;
      end
    end

`ifdef DS_RX_DISCONNECT_EN
    disc_cnt_d = disc_cnt_q;
    if (bit_vld) begin
      disc_cnt_d = '0;
    end else if (link_up_q) begin
      if (disc_cnt_q == DW'(DISC_CYCLES - 1)) begin
        ev_disc    = 1'b1;
        disc_cnt_d = '0;
      end else begin
        disc_cnt_d = disc_cnt_q + 1'b1;
      end
    end
    err_disc_d = (err_disc_q & ~err_clr) | ev_disc;
`endif

    // Framing errors resync from scratch; overrun only drops the link indication.
    if (ev_par || ev_esc || ev_disc) begin
      state_d    = HUNT;
      hist_d     = 7'd0;
      esc_pend_d = 1'b0;
    end
    if (ev_par || ev_esc || ev_ovr || ev_disc) link_up_d = 1'b0;

    err_par_d = (err_par_q & ~err_clr) | ev_par;
    err_esc_d = (err_esc_q & ~err_clr) | ev_esc;
    err_ovr_d = (err_ovr_q & ~err_clr) | ev_ovr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      d_s1_q     <= 1'b0;
      d_s2_q     <= 1'b0;
      s_s1_q     <= 1'b0;
      s_s2_q     <= 1'b0;
      tok_q      <= 1'b0;
      hist_q     <= 7'd0;
      cnt_q      <= 3'd0;
      body_q     <= 8'h00;
      flag_q     <= 1'b0;
      par_acc_q  <= 1'b0;
      par_chk_q  <= 1'b0;
      esc_pend_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_ctrl_q  <= 1'b0;
      rx_data_q  <= 8'h00;
      link_up_q  <= 1'b0;
      err_par_q  <= 1'b0;
      err_esc_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_s1_q     <= d_s1_d;
      d_s2_q     <= d_s2_d;
      s_s1_q     <= s_s1_d;
      s_s2_q     <= s_s2_d;
      tok_q      <= tok_d;
      hist_q     <= hist_d;
      cnt_q      <= cnt_d;
      body_q     <= body_d;
      flag_q     <= flag_d;
      par_acc_q  <= par_acc_d;
      par_chk_q  <= par_chk_d;
      esc_pend_q <= esc_pend_d;
      rx_valid_q <= rx_valid_d;
      rx_ctrl_q  <= rx_ctrl_d;
      rx_data_q  <= rx_data_d;
      link_up_q  <= link_up_d;
      err_par_q  <= err_par_d;
      err_esc_q  <= err_esc_d;
      err_ovr_q  <= err_ovr_d;
    end
  end

`ifdef DS_RX_DISCONNECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disc_cnt_q <= '0;
      err_disc_q <= 1'b0;
    end else begin
      disc_cnt_q <= disc_cnt_d;
      err_disc_q <= err_disc_d;
    end
  end
  assign err_disc = err_disc_q;
`else
  assign err_disc = 1'b0;
`endif

  assign rx_valid = rx_valid_q;
  assign rx_ctrl  = rx_ctrl_q;
  assign rx_data  = rx_data_q;
  assign link_up  = link_up_q;
  assign err_par  = err_par_q;
  assign err_esc  = err_esc_q;
  assign err_ovr  = err_ovr_q;

endmodule

// File: tb/tb_ds_rx_decoder.sv
// Scoreboard bench for ds_rx_decoder: DS-encodes directed characters, checks deliveries and status flags.
module tb_ds_rx_decoder;

  localparam int BIT_CYC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d_in = 1'b0;
  logic       s_in = 1'b0;
  logic       rx_ready = 1'b1;
  logic       err_clr = 1'b0;
  logic       rx_valid, rx_ctrl, link_up;
  logic [7:0] rx_data;
  logic       err_par, err_esc, err_ovr, err_disc;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];
  logic prev_par = 1'b0;

  ds_rx_decoder #(.DISC_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .s_in(s_in),
    .rx_ready(rx_ready), .err_clr(err_clr),
    .rx_valid(rx_valid), .rx_ctrl(rx_ctrl), .rx_data(rx_data),
    .link_up(link_up), .err_par(err_par), .err_esc(err_esc),
    .err_ovr(err_ovr), .err_disc(err_disc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Monitor: every accepted character is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_char: got ctrl=%0b data=%02h, required none", rx_ctrl, rx_data);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({rx_ctrl, rx_data} !== e) begin
          n_bad++;
          $display("FAIL char: got ctrl=%0b data=%02h, required ctrl=%0b data=%02h",
                   rx_ctrl, rx_data, e[8], e[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %02h, required %02h", name, act, req);
    end
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk);
    #1;
    if (b == d_in) s_in = ~s_in;
    d_in = b;
    repeat (BIT_CYC - 1) @(posedge clk);
  endtask

  task automatic send_char(input logic flag, input logic [7:0] val, input logic bad_par);
    int n;
    logic p, bp;
    n  = flag ? 2 : 8;
    p  = 1'b1 ^ flag ^ prev_par ^ bad_par;
    bp = 1'b0;
    send_bit(p);
    send_bit(flag);
    for (int i = 0; i < n; i++) begin
      send_bit(val[i]);
      bp = bp ^ val[i];
    end
    prev_par = bp;
  endtask

  task automatic send_null();
    send_char(1'b1, 8'd3, 1'b0);
    send_char(1'b1, 8'd0, 1'b0);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic exp_disc, exp_link;
    repeat (3) @(negedge clk);
    check("rst_rx_valid", {7'd0, rx_valid}, 8'd0);
    check("rst_rx_ctrl",  {7'd0, rx_ctrl},  8'd0);
    check("rst_rx_data",  rx_data,          8'h00);
    check("rst_link_up",  {7'd0, link_up},  8'd0);
    check("rst_errs", {4'd0, err_par, err_esc, err_ovr, err_disc}, 8'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Sync and a data character
    send_null();
    settle();
    check("link_after_null", {7'd0, link_up}, 8'd1);
    send_null();
    exp_q.push_back({1'b0, 8'hA5});
    send_char(1'b0, 8'hA5, 1'b0);
    settle();

    // Control characters; NULLs are swallowed, lone FCC is delivered
    exp_q.push_back({1'b1, 8'h01});
    send_char(1'b1, 8'd1, 1'b0);
    send_null();
    send_null();
    exp_q.push_back({1'b1, 8'h02});
    send_char(1'b1, 8'd2, 1'b0);
    exp_q.push_back({1'b1, 8'h00});
    send_char(1'b1, 8'd0, 1'b0);
    settle();
    check("no_err_after_ctrl", {4'd0, err_par, err_esc, err_ovr, err_disc}, 8'd0);

    // Parity error
    send_char(1'b0, 8'h3C, 1'b1);
    settle();
    check("par_err_set", {7'd0, err_par}, 8'd1);
    check("par_link_down", {7'd0, link_up}, 8'd0);
    pulse_clr();
    check("par_err_clr", {7'd0, err_par}, 8'd0);
    send_null();
    settle();
    check("par_resync", {7'd0, link_up}, 8'd1);
    exp_q.push_back({1'b0, 8'h5A});
    send_char(1'b0, 8'h5A, 1'b0);
    settle();

    // Overrun: held 0x11 survives, 0x22 discarded
    @(posedge clk); #1 rx_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h11});
    send_char(1'b0, 8'h11, 1'b0);
    send_char(1'b0, 8'h22, 1'b0);
    settle();
    check("ovr_valid_held", {7'd0, rx_valid}, 8'd1);
    check("ovr_data_held", rx_data, 8'h11);
    check("ovr_err_set", {7'd0, err_ovr}, 8'd1);
    @(posedge clk); #1 rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_valid_drop", {7'd0, rx_valid}, 8'd0);
    pulse_clr();
    check("ovr_err_clr", {7'd0, err_ovr}, 8'd0);
    send_null();
    settle();
    check("ovr_link_back", {7'd0, link_up}, 8'd1);

    // ESC followed by a non-FCC control
    send_char(1'b1, 8'd3, 1'b0);
    send_char(1'b1, 8'd2, 1'b0);
    settle();
    check("esc_err_set", {7'd0, err_esc}, 8'd1);
    check("esc_link_down", {7'd0, link_up}, 8'd0);
    send_char(1'b0, 8'h77, 1'b0);
    settle();
    check("esc_still_hunting", {7'd0, link_up}, 8'd0);
    send_null();
    settle();
    check("esc_resync", {7'd0, link_up}, 8'd1);
    pulse_clr();
    check("esc_err_clr", {7'd0, err_esc}, 8'd0);
    exp_q.push_back({1'b0, 8'h42});
    send_char(1'b0, 8'h42, 1'b0);
    settle();

    // Idle lines
`ifdef DS_RX_DISCONNECT_EN
    exp_disc = 1'b1;
    exp_link = 1'b0;
`else
    exp_disc = 1'b0;
    exp_link = 1'b1;
`endif
    repeat (70) @(negedge clk);
    check("idle_err_disc", {7'd0, err_disc}, {7'd0, exp_disc});
    check("idle_link_up",  {7'd0, link_up},  {7'd0, exp_link});
    pulse_clr();
    send_null();
    settle();

    // Reset mid-character
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_link", {7'd0, link_up}, 8'd0);
    check("midrst_valid", {7'd0, rx_valid}, 8'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (BIT_CYC * 4) @(negedge clk);
    check("postrst_no_link", {7'd0, link_up}, 8'd0);
    send_null();
    settle();
    check("postrst_link", {7'd0, link_up}, 8'd1);
    exp_q.push_back({1'b0, 8'h99});
    send_char(1'b0, 8'h99, 1'b0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ds_rx_decoder.md
DS_RX_DECODER -- requirements
Module: ds_rx_decoder

Interface
REQ-001 Parameter DISC_CYCLES, default 64, is the idle clock count with no d/s transition that flags disconnect.
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 d_in  in  1  IEEE 1355 DS data line, asynchronous to clk.
REQ-005 s_in  in  1  IEEE 1355 DS strobe line, asynchronous to clk.
REQ-006 rx_ready  in  1  consumer accepts the held character this cycle.
REQ-007 err_clr  in  1  single-cycle pulse that clears all sticky error flags.
REQ-008 rx_valid  out  1  a decoded character is held.
REQ-009 rx_ctrl  out  1  held character is control (1) or data (0).
REQ-010 rx_data  out  8  data byte, or control code in [1:0] with [7:2]=0.
REQ-011 link_up  out  1  NULL sync achieved; characters are being framed.
REQ-012 err_par, err_esc, err_ovr, err_disc  out  1 each  sticky parity, escape, overrun, disconnect errors.

Function
REQ-013 d_in and s_in each pass through a 2-flop synchroniser; the bit-edge token is d^s after synchronisation.
REQ-014 A received bit is captured when the token differs from its previous-cycle value; bit value = synchronised d.
REQ-015 Bit order per character: parity, flag, then 8 data bits LSB first (flag=0) or 2 control bits LSB first (flag=1).
REQ-016 Control codes: 00 FCC, 01 EOP_1, 10 EOP_2, 11 ESC.
REQ-017 States: HUNT, PARITY, FLAG, BODY; bit counter 0..7 in BODY.
REQ-018 HUNT: shift received bits into a 7-bit history; on match with arrival sequence 1,1,1,0,1,0,0 (tail of NULL), go to PARITY, set link_up, and seed the parity accumulator for the FCC.
REQ-019 PARITY->FLAG->BODY on successive bits; BODY exits to PARITY after 8 data bits or 2 control bits.
REQ-020 Odd parity: parity bit + flag of current char + body bits of previous char SHALL have an odd count of 1s; on violation set err_par and go to HUNT.
REQ-021 ESC immediately followed by FCC (NULL) is consumed and not delivered.
REQ-022 ESC followed by any character other than FCC sets err_esc and goes to HUNT; neither character is delivered.
REQ-023 FCC, EOP_1, EOP_2 and data characters are delivered: rx_valid rises the cycle after the final body bit is captured.
REQ-024 rx_valid, rx_ctrl, rx_data hold stable until the cycle rx_valid and rx_ready are both high; rx_valid falls the next cycle unless a new character completes that same cycle, in which case the new character is loaded and rx_valid stays high.
REQ-025 Character completing while rx_valid=1 and rx_ready=0: new character discarded, held one kept, err_ovr set; framing continues.
REQ-026 Any error drops link_up; held character remains valid until accepted.
REQ-027 err_clr clears all four flags; an error event in the same cycle wins (flag stays set).

Reset
REQ-028 While rst_n=0: state HUNT, history/counters/synchronisers 0, rx_valid=0, rx_ctrl=0, rx_data=0, link_up=0, all error flags 0.
REQ-029 Reset asserted mid-character aborts it with no delivery; after release the decoder hunts for NULL again.

Configuration
REQ-030 Macro DS_RX_DISCONNECT_EN defined: a counter resets on every captured bit, counts while link_up=1, and on reaching DISC_CYCLES sets err_disc, drops link_up, goes to HUNT.
REQ-031 Macro DS_RX_DISCONNECT_EN undefined: no counter; err_disc tied to 0; link never drops on idle.

Verification
REQ-032 Send NULL,NULL then data 0xA5 with rx_ready=1 -> link_up=1 after first NULL; one rx_valid pulse with rx_ctrl=0, rx_data=0xA5.
REQ-033 After sync send EOP_1 -> rx_valid with rx_ctrl=1, rx_data=0x01; NULLs produce no rx_valid.
REQ-034 Sync, then data 0x3C with parity bit inverted -> err_par=1, link_up=0, no delivery; err_clr pulse -> err_par=0.
REQ-035 rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, err_ovr=1; raise rx_ready -> 0x11 accepted, rx_valid=0 next cycle.
REQ-036 Sync, send ESC then EOP_2 -> err_esc=1, nothing delivered, HUNT until next NULL.
REQ-037 With DS_RX_DISCONNECT_EN, DISC_CYCLES=64: after sync hold lines static 64 cycles -> err_disc=1, link_up=0; without macro -> err_disc stays 0, link_up stays 1.
